// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and sequencing controller for the PC, IF_ID, ID_EXE
// and EXE_MEM pipeline registers. Produces write enables and flushes for
// load-use stalls, taken branches, multi-cycle DIV/DIVU and MEM exceptions,
// and owns the divider start/abort handshake.
//
// Optional feature: define PIPE_CTRL_PERF_EN to add saturating 32-bit
// stall/flush cycle counters (Perf_StallCnt, Perf_FlushCnt). Without it the
// ports and counters are absent and control behaviour is identical.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | normal flow; load-use, branch and new DIV requests decoded
// ST_DIV      | divide in flight; cnt!=0 stall, cnt==0 release cycle
// ST_REDIRECT | post-exception; IFID_Flush held while cnt counts down
//
// Outputs are combinational from state/cnt and the current inputs, and are
// forced to their idle values while rst is high.

module pipeline_ctrl #(
  parameter int unsigned DIV_LATENCY     = 32,
  parameter int unsigned REDIRECT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        EXE_ReadMem,
  input  logic [4:0]  EXE_Dst,
  input  logic        EXE_DivReq,
  input  logic        EXE_BranchTaken,
  input  logic        MEM_ExceptValid,
  output logic        IF_PCWr,
  output logic        IF_IDWr,
  output logic        IDEXE_Wr,
  output logic        IFID_Flush,
  output logic        IDEXE_Flush,
  output logic        EXEMEM_Flush,
  output logic        Div_Start,
  output logic        Div_Abort
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] Perf_StallCnt,
  output logic [31:0] Perf_FlushCnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DIV      = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  // The request cycle is the first of DIV_LATENCY stall cycles, so the
  // counter is loaded with the number of stall cycles still owed after it;
  // the cycle with cnt==0 is the release cycle that follows the last stall.
  localparam logic [5:0] DIV_LOAD   = 6'(DIV_LATENCY - 1);
  localparam logic [5:0] REDIR_LOAD = 6'(REDIRECT_CYCLES - 1);

  state_t     state;
  logic [5:0] cnt;
  logic       load_use;

  // Register $0 is hard-wired, so a load targeting it never creates a hazard.
  assign load_use = EXE_ReadMem && (EXE_Dst != 5'd0) &&
                    ((EXE_Dst == ID_rs) || (EXE_Dst == ID_rt));

  // Output decode, priority exception > DIV stall > load-use > branch.
  always_comb begin
    IF_PCWr      = 1'b1;
    IF_IDWr      = 1'b1;
    IDEXE_Wr     = 1'b1;
    IFID_Flush   = 1'b0;
    IDEXE_Flush  = 1'b0;
    EXEMEM_Flush = 1'b0;
    Div_Start    = 1'b0;
    Div_Abort    = 1'b0;
    if (!rst) begin
      if (MEM_ExceptValid) begin
        IFID_Flush   = 1'b1;
        IDEXE_Flush  = 1'b1;
        EXEMEM_Flush = 1'b1;
        Div_Abort    = (state == ST_DIV) || ((state == ST_IDLE) && EXE_DivReq);
      end else begin
        case (state)
          ST_REDIRECT: IFID_Flush = 1'b1;
          ST_DIV: begin
            if (cnt != 6'd0) begin
              IF_PCWr      = 1'b0;
              IF_IDWr      = 1'b0;
              IDEXE_Wr     = 1'b0;
              EXEMEM_Flush = 1'b1;
            end
          end
          ST_IDLE: begin
            if (EXE_DivReq) begin
              Div_Start    = 1'b1;
              IF_PCWr      = 1'b0;
              IF_IDWr      = 1'b0;
              IDEXE_Wr     = 1'b0;
              EXEMEM_Flush = 1'b1;
            end else if (load_use) begin
              IF_PCWr     = 1'b0;
              IF_IDWr     = 1'b0;
              IDEXE_Flush = 1'b1;
            end else if (EXE_BranchTaken) begin
              IFID_Flush = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // State and down-counter; the counter never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 6'd0;
    end else if (MEM_ExceptValid) begin
      state <= ST_REDIRECT;
      cnt   <= REDIR_LOAD;
    end else begin
      case (state)
        ST_IDLE: begin
          if (EXE_DivReq) begin
            state <= ST_DIV;
            cnt   <= DIV_LOAD;
          end
        end
        ST_DIV, ST_REDIRECT: begin
          if (cnt == 6'd0) state <= ST_IDLE;
          else             cnt   <= cnt - 6'd1;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= 6'd0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic any_flush;
  assign any_flush = IFID_Flush || IDEXE_Flush || EXEMEM_Flush;

  // Saturating counts of fetch-stall cycles and cycles with any flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      Perf_StallCnt <= 32'd0;
      Perf_FlushCnt <= 32'd0;
    end else begin
      if (!IF_PCWr && (Perf_StallCnt != 32'hFFFF_FFFF))
        Perf_StallCnt <= Perf_StallCnt + 32'd1;
      if (any_flush && (Perf_FlushCnt != 32'hFFFF_FFFF))
        Perf_FlushCnt <= Perf_FlushCnt + 32'd1;
    end
  end
`endif

endmodule
